// File: rtl/seg_scan_n.sv
// Multi-digit common-anode 7-segment scan driver with a sequential binary-to-BCD
// converter, leading-zero blanking, decimal points, overflow dashes and blink.
module seg_scan_n #(
  parameter int DIGITS    = 4,
  parameter int DATA_W    = 14,
  parameter int SCAN_DIV  = 65536,
  parameter int BLINK_DIV = 12000000
) (
  input  logic              clk_24m,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  input  logic              blink_en,
  output logic              busy,
  output logic [7:0]        sm_seg,
  output logic [DIGITS-1:0] sm_bit
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BL_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS) - 64'd1;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] bin_sr, bin_sr_nx;
  logic [BCD_W-1:0]  bcd_sr, bcd_sr_nx, bcd_adj;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
  logic              ovf_pend, ovf_pend_nx;
  logic [BCD_W-1:0]  disp_bcd, disp_bcd_nx;
  logic              disp_ovf, disp_ovf_nx;

  logic [SC_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]  dig_idx;
  logic [BL_W-1:0]   blink_cnt;
  logic              blink_on;

  logic [3:0]        cur_nib;
  logic              blank_cur;
  logic [7:0]        seg_nx;
  logic [DIGITS-1:0] bit_nx;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h40;
    endcase
  endfunction

  assign busy = (state != IDLE);

  always_comb begin
    state_nx    = state;
    bin_sr_nx   = bin_sr;
    bcd_sr_nx   = bcd_sr;
    bit_cnt_nx  = bit_cnt;
    ovf_pend_nx = ovf_pend;
    disp_bcd_nx = disp_bcd;
    disp_ovf_nx = disp_ovf;
    bcd_adj     = bcd_sr;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    unique case (state)
      IDLE: if (data_valid) begin
        state_nx    = SHIFT;
        bin_sr_nx   = data_in;
        bcd_sr_nx   = '0;
        bit_cnt_nx  = '0;
        ovf_pend_nx = (64'(data_in) > MAX_VAL);
      end
      SHIFT: begin
        bcd_sr_nx  = {bcd_adj[BCD_W-2:0], bin_sr[DATA_W-1]};
        bin_sr_nx  = {bin_sr[DATA_W-2:0], 1'b0};
        bit_cnt_nx = bit_cnt + 1'b1;
        if (bit_cnt == CNT_W'(DATA_W - 1)) state_nx = LOAD;
      end
      LOAD: begin
        disp_bcd_nx = bcd_sr;
        disp_ovf_nx = ovf_pend;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_24m) begin
    if (!rst_n) begin
      state    <= IDLE;
      bin_sr   <= '0;
      bcd_sr   <= '0;
      bit_cnt  <= '0;
      ovf_pend <= 1'b0;
      disp_bcd <= '0;
      disp_ovf <= 1'b0;
    end else begin
      state    <= state_nx;
      bin_sr   <= bin_sr_nx;
      bcd_sr   <= bcd_sr_nx;
      bit_cnt  <= bit_cnt_nx;
      ovf_pend <= ovf_pend_nx;
      disp_bcd <= disp_bcd_nx;
      disp_ovf <= disp_ovf_nx;
    end
  end

  // A digit blanks only when it and every digit above it are zero; digit 0 never blanks
  always_comb begin
    cur_nib   = disp_bcd[{dig_idx, 2'b00} +: 4];
    blank_cur = blank_lz && (dig_idx != '0);
    for (int unsigned i = 0; i < DIGITS; i++)
      if ((IDX_W'(i) >= dig_idx) && (disp_bcd[4*i +: 4] != 4'd0)) blank_cur = 1'b0;
    if (disp_ovf)       seg_nx = {~dp_mask[dig_idx], 7'h3F};
    else if (blank_cur) seg_nx = {~dp_mask[dig_idx], 7'h7F};
    else                seg_nx = {~dp_mask[dig_idx], seg7(cur_nib)};
    bit_nx = '1;
    if (!(blink_en && !blink_on)) bit_nx[dig_idx] = 1'b0;
  end

  always_ff @(posedge clk_24m) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      dig_idx   <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      sm_bit    <= '1;
      sm_seg    <= '1;
    end else begin
      if (scan_cnt == SC_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        dig_idx  <= (dig_idx == IDX_W'(DIGITS - 1)) ? '0 : dig_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (blink_cnt == BL_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      sm_bit <= bit_nx;
      sm_seg <= seg_nx;
    end
  end

endmodule

// File: tb/tb_seg_scan_n.sv
// Bench for seg_scan_n: per-cycle check against a decimal-arithmetic display model,
// plus directed literal checks of reset, conversion, blanking, overflow and blink.
module tb_seg_scan_n;

  localparam int DIGITS    = 4;
  localparam int DATA_W    = 14;
  localparam int SCAN_DIV  = 8;
  localparam int BLINK_DIV = 100;

  logic              clk_24m = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              blank_lz;
  logic [DIGITS-1:0] dp_mask;
  logic              blink_en;
  logic              busy;
  logic [7:0]        sm_seg;
  logic [DIGITS-1:0] sm_bit;

  always #5 clk_24m = ~clk_24m;

  seg_scan_n #(
    .DIGITS   (DIGITS),
    .DATA_W   (DATA_W),
    .SCAN_DIV (SCAN_DIV),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk_24m   (clk_24m),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .data_valid(data_valid),
    .blank_lz  (blank_lz),
    .dp_mask   (dp_mask),
    .blink_en  (blink_en),
    .busy      (busy),
    .sm_seg    (sm_seg),
    .sm_bit    (sm_bit)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int val, input int k, input logic bl,
                                         input logic [DIGITS-1:0] dm);
    int p;
    int lim;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    lim = lim - 1;
    if (val > lim) return {~dm[k], 7'h3F};
    if (bl && k > 0 && val < p) return {~dm[k], 7'h7F};
    return {~dm[k], seg_tab[(val / p) % 10][6:0]};
  endfunction

  // Model: edges since reset give scan/blink phase; accepted strobes land DATA_W+1 edges later
  int  m_n, m_last, m_load_at, m_pend, m_val;
  bit  m_have, m_started = 0;
  logic [DIGITS-1:0] e_bit;
  logic [7:0]        e_seg;
  logic              e_busy;

  always @(posedge clk_24m) begin
    int idx;
    bit on;
    if (!rst_n) begin
      m_started = 1;
      m_n = 0; m_last = -1000; m_have = 0; m_val = 0;
      e_bit = '1; e_seg = 8'hFF; e_busy = 1'b0;
    end else if (m_started) begin
      m_n++;
      if (m_have && m_load_at < m_n) begin
        m_val  = m_pend;
        m_have = 0;
      end
      idx   = ((m_n - 1) / SCAN_DIV) % DIGITS;
      on    = (((m_n - 1) / BLINK_DIV) % 2) == 0;
      e_bit = '1;
      if (!(blink_en && !on)) e_bit[idx] = 1'b0;
      e_seg = exp_seg(m_val, idx, blank_lz, dp_mask);
      if (data_valid && m_n >= m_last + DATA_W + 2) begin
        m_last    = m_n;
        m_pend    = int'(data_in);
        m_have    = 1;
        m_load_at = m_n + DATA_W + 1;
      end
      e_busy = (m_n <= m_last + DATA_W);
    end
    if (m_started) begin
      #1;
      check("model_sm_bit", 32'(sm_bit), 32'(e_bit));
      check("model_sm_seg", 32'(sm_seg), 32'(e_seg));
      check("model_busy",   32'(busy),   32'(e_busy));
    end
  end

  task automatic seg_of_digit(input int k, output logic [7:0] s);
    logic [DIGITS-1:0] tgt;
    tgt = '1;
    tgt[k] = 1'b0;
    s = 8'h00;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_24m);
      if (sm_bit == tgt) begin
        s = sm_seg;
        return;
      end
    end
    check("scan_timeout", 32'(sm_bit), 32'(tgt));
  endtask

  task automatic expect_digits(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] s;
    logic [7:0] want [4];
    want = '{d0, d1, d2, d3};
    for (int k = 0; k < DIGITS; k++) begin
      seg_of_digit(k, s);
      check($sformatf("%s_d%0d", tag, k), 32'(s), 32'(want[k]));
    end
  endtask

  task automatic send(input int v, output int busy_cycles);
    @(negedge clk_24m);
    data_in    = DATA_W'(v);
    data_valid = 1'b1;
    @(negedge clk_24m);
    data_valid  = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      busy_cycles++;
      @(negedge clk_24m);
    end
    repeat (2) @(negedge clk_24m);
  endtask

  task automatic run_length(input logic [DIGITS-1:0] pat, output int len);
    len = 0;
    for (int i = 0; i < 300 && sm_bit == pat; i++) begin
      len++;
      @(negedge clk_24m);
    end
  endtask

  task automatic wait_for(input logic [DIGITS-1:0] pat, input bit want_eq);
    for (int i = 0; i < 300; i++) begin
      if ((sm_bit == pat) == want_eq) return;
      @(negedge clk_24m);
    end
    check("wait_timeout", 32'(sm_bit), 32'(pat));
  endtask

  initial begin
    int bc;
    int len;
    int v;
    int r;
    rst_n = 1'b0; data_in = '0; data_valid = 1'b0;
    blank_lz = 1'b0; dp_mask = '0; blink_en = 1'b0;
    repeat (3) @(negedge clk_24m);
    check("rst_sm_bit", 32'(sm_bit), 32'h0000_000F);
    check("rst_sm_seg", 32'(sm_seg), 32'h0000_00FF);
    check("rst_busy",   32'(busy),   32'h0);
    rst_n = 1'b1;

    expect_digits("zero", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    wait_for(4'b1101, 1'b1);
    run_length(4'b1101, len);
    check("scan_dwell", 32'(len), 32'(SCAN_DIV));

    send(1234, bc);
    check("busy_len_1234", 32'(bc), 32'd15);
    expect_digits("v1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    blank_lz = 1'b1; dp_mask = 4'b0010;
    send(7, bc);
    expect_digits("v7_lz", 8'hF8, 8'h7F, 8'hFF, 8'hFF);

    dp_mask = '0;
    send(10000, bc);
    expect_digits("ovf", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

    blank_lz = 1'b0;
    @(negedge clk_24m);
    data_in = DATA_W'(42); data_valid = 1'b1;
    @(negedge clk_24m);
    data_valid = 1'b0;
    repeat (3) @(negedge clk_24m);
    data_in = DATA_W'(99); data_valid = 1'b1;
    @(negedge clk_24m);
    data_valid = 1'b0;
    repeat (30) @(negedge clk_24m);
    expect_digits("v42", 8'hA4, 8'h99, 8'hC0, 8'hC0);

    blink_en = 1'b1;
    wait_for('1, 1'b0);
    wait_for('1, 1'b1);
    run_length('1, len);
    check("blink_off_len", 32'(len), 32'(BLINK_DIV));
    len = 0;
    for (int i = 0; i < 300 && sm_bit != '1; i++) begin
      len++;
      @(negedge clk_24m);
    end
    check("blink_on_len", 32'(len), 32'(BLINK_DIV));
    blink_en = 1'b0;

    @(negedge clk_24m);
    data_in = DATA_W'(5000); data_valid = 1'b1;
    @(negedge clk_24m);
    data_valid = 1'b0;
    repeat (4) @(negedge clk_24m);
    rst_n = 1'b0;
    @(negedge clk_24m);
    check("midrst_busy",   32'(busy),   32'h0);
    check("midrst_sm_bit", 32'(sm_bit), 32'h0000_000F);
    rst_n = 1'b1;
    expect_digits("after_rst", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    for (int t = 0; t < 60; t++) begin
      blank_lz = 1'($urandom_range(0, 1));
      dp_mask  = DIGITS'($urandom);
      blink_en = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 9));
      if (r < 6)       v = int'($urandom_range(0, 9999));
      else if (r < 8)  v = int'($urandom_range(0, 120));
      else if (r == 8) v = (t % 2 != 0) ? 9999 : 10000;
      else             v = int'($urandom_range(10000, 16383));
      repeat ($urandom_range(0, 6)) @(negedge clk_24m);
      data_in = DATA_W'(v); data_valid = 1'b1;
      @(negedge clk_24m);
      data_valid = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 16)) @(negedge clk_24m);
        data_in = DATA_W'($urandom); data_valid = 1'b1;
        @(negedge clk_24m);
        data_valid = 1'b0;
      end
      repeat ($urandom_range(10, 60)) @(negedge clk_24m);
    end
    blink_en = 1'b0;
    repeat (40) @(negedge clk_24m);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
